vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates pixel-enable, h/v counters, sync, blanking and scaled logical coordinates for any mode via parameters.
- Adds sync polarity control, a stall-free PIPE-stage alignment delay for frame-buffer read latency, and frame/line strobes.
- Sits between clk_100MHz and the frame-buffer reader and colour mux.
- The pixel clock is a clock enable, never a derived clock.

Parameters:
- CLK_DIV, 4: system clocks per pixel, ≥2.
- HD, 640: horizontal active pixels.
- HF, 16: horizontal front porch.
- HS, 96: hsync width.
- HB, 48: horizontal back porch.
- VD, 480: active lines.
- VF, 10: vertical front porch.
- VS, 2: vsync width.
- VB, 33: vertical back porch.
- H_POL, 0: hsync active level (0 = active-low).
- V_POL, 0: vsync active level.
- X_SCALE, 4: pixels per logical x.
- Y_SCALE, 4: lines per logical y.
- PIPE, 2: extra p_tick stages applied to sync/video_on/x/y/strobes, 0..8.
- CW, 11: h/v counter and x/y width.

Ports:
- clk_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run when 1; when 0, counters freeze at current value.
- p_tick  out  1  one-clk pulse per pixel.
- h_count  out  CW  raw horizontal position, undelayed.
- v_count  out  CW  raw vertical position, undelayed.
- hsync  out  1  horizontal sync, delayed PIPE.
- vsync  out  1  vertical sync, delayed PIPE.
- video_on  out  1  active area, delayed PIPE.
- x  out  CW  logical x = h/X_SCALE, delayed PIPE.
- y  out  CW  logical y = v/Y_SCALE, delayed PIPE.
- frame_start  out  1  pulse at h=0,v=0, delayed PIPE.
- line_end  out  1  pulse at h=HMAX, delayed PIPE.

Behaviour:
- Reset (async assert, sync release) values:
  - Divider, h_count, v_count, x, y: 0.
  - p_tick, video_on, frame_start, line_end: 0.
  - hsync = ~H_POL, vsync = ~V_POL.
  - All delay stages hold these same inactive values.
- Divider counts 0..CW_DIV-1 only while enable=1. p_tick=1 on the clk where the divider equals CLK_DIV-1; the divider wraps to 0 on that same clk.
- Counters: HMAX = HD+HF+HS+HB-1 (799 at defaults), VMAX = VD+VF+VS+VB-1 (524).
  - On p_tick: h increments, or wraps to 0 at HMAX.
  - v advances only on the HMAX wrap, and wraps to 0 at VMAX.
- Region order per line: active, front porch, sync, back porch.
  - hsync asserted for HD+HF ≤ h ≤ HD+HF+HS-1 (656..751 at defaults).
  - vsync asserted for VD+VF ≤ v ≤ VD+VF+VS-1 (490..491).
- video_on = (h<HD)&&(v<VD).
- x and y use sub-counters, not dividers.
  - xs counts 0..X_SCALE-1. x increments when xs wraps. Both clear at h wrap.
  - ys/y behave the same on line wrap, clearing at v wrap.
  - x and y continue counting in blanking; x = floor(h/X_SCALE) holds for every h.
- Timing stage: registered on p_tick from the counter values, giving 1 pixel of latency.
- Delay line: PIPE further stages, each advancing only on p_tick. Total latency of the delayed outputs relative to h_count is 1+PIPE pixels.
- frame_start and line_end are one system clk wide: high only on the p_tick clk that loads them into the final stage.
- enable=0 mid-line: p_tick stops, all state holds, outputs hold their levels. Strobes are forced to 0 while stalled.
- enable and reset_n are both low: reset wins.
- Elaboration check: parameter values that would make HMAX or VMAX overflow CW must fail elaboration.

Decomposition:
- Shared package vga_pkg holds:
  - Default mode constants for 640x480@60 and 800x600@60 (from a 40 MHz-equivalent divider).
  - Function calc_max(d,f,s,b).
  - Sync polarity localparams.
- One natural sub-module: vga_sync_delay, a parametrised DEPTH×WIDTH shift register enabled by p_tick, with reset value supplied by parameter. It carries {hsync, vsync, video_on, frame_start, line_end, x, y}.

Test Plan:
- Reset with enable=1, defaults:
  - First p_tick on clk 4 after release; p_tick period is exactly 4 clk.
  - One frame = 800×525×4 = 1,680,000 clk.
  - frame_start recurs at exactly that period.
- Defaults, one line:
  - hsync low for exactly 96 p_ticks.
  - Its falling edge comes 1+PIPE=3 p_ticks after h_count=656.
  - video_on high for 640 p_ticks per active line and 0 on v=480..524.
- x/y mapping:
  - For every h, the delayed x equals floor(h/4); x=159 at h=639 and x=199 at h=799.
  - y=119 at v=479; y=0 after v wrap at 524→0.
- Stall:
  - Drop enable at h=300 for 50 clk, then raise it.
  - h_count holds 300 and no p_tick or strobe occurs.
  - Afterwards the line totals remain 800 p_ticks.
- Reset mid-frame at v=200:
  - All outputs go to reset values asynchronously, in the same clk, including sync at its inactive level and delay contents cleared.
  - After release, the frame restarts at h=v=0.
- Param sweep CLK_DIV=2, H_POL=V_POL=1, PIPE=0, X_SCALE=Y_SCALE=1:
  - Active-high syncs.
  - Outputs lag h_count by 1 pixel.
  - x==h throughout the line.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA mode constants, sync polarity encodings and timing helpers.
package vga_pkg;

  // Sync polarity encodings for H_POL / V_POL.
  localparam int unsigned SYNC_ACTIVE_LOW  = 0;
  localparam int unsigned SYNC_ACTIVE_HIGH = 1;

  // 640x480@60: 25 MHz pixel rate from a 100 MHz system clock.
  localparam int unsigned M640_CLK_DIV = 4;
  localparam int unsigned M640_HD      = 640;
  localparam int unsigned M640_HF      = 16;
  localparam int unsigned M640_HS      = 96;
  localparam int unsigned M640_HB      = 48;
  localparam int unsigned M640_VD      = 480;
  localparam int unsigned M640_VF      = 10;
  localparam int unsigned M640_VS      = 2;
  localparam int unsigned M640_VB      = 33;
  localparam int unsigned M640_H_POL   = SYNC_ACTIVE_LOW;
  localparam int unsigned M640_V_POL   = SYNC_ACTIVE_LOW;

  // 800x600@60: 40 MHz pixel rate, divider assumes an 80 MHz system clock.
  localparam int unsigned M800_CLK_DIV = 2;
  localparam int unsigned M800_HD      = 800;
  localparam int unsigned M800_HF      = 40;
  localparam int unsigned M800_HS      = 128;
  localparam int unsigned M800_HB      = 88;
  localparam int unsigned M800_VD      = 600;
  localparam int unsigned M800_VF      = 1;
  localparam int unsigned M800_VS      = 4;
  localparam int unsigned M800_VB      = 23;
  localparam int unsigned M800_H_POL   = SYNC_ACTIVE_HIGH;
  localparam int unsigned M800_V_POL   = SYNC_ACTIVE_HIGH;

  // Last counter value of a line or frame given its four region lengths.
  function automatic int unsigned calc_max(input int unsigned d, input int unsigned f,
                                           input int unsigned s, input int unsigned b);
    return d + f + s + b - 1;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH x WIDTH shift register advancing on a clock enable, with a
// parameter-supplied reset value for every stage.
module vga_sync_delay #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_100MHz,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH < 1) begin : g_depth_check
    $error("vga_sync_delay: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] sr [DEPTH];

  // Shift one stage per enable; all stages clear to the inactive value.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= RST_VAL;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel clock enable, raw h/v counters,
// and sync/blank/logical coordinates/strobes delayed to match frame-buffer latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = M640_CLK_DIV,
  parameter int unsigned HD      = M640_HD,
  parameter int unsigned HF      = M640_HF,
  parameter int unsigned HS      = M640_HS,
  parameter int unsigned HB      = M640_HB,
  parameter int unsigned VD      = M640_VD,
  parameter int unsigned VF      = M640_VF,
  parameter int unsigned VS      = M640_VS,
  parameter int unsigned VB      = M640_VB,
  parameter int unsigned H_POL   = M640_H_POL,
  parameter int unsigned V_POL   = M640_V_POL,
  parameter int unsigned X_SCALE = 4,
  parameter int unsigned Y_SCALE = 4,
  parameter int unsigned PIPE    = 2,
  parameter int unsigned CW      = 11
) (
  input  logic          clk_100MHz,
  input  logic          reset_n,
  input  logic          enable,
  output logic          p_tick,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          line_end
);

  localparam int unsigned HMAX     = calc_max(HD, HF, HS, HB);
  localparam int unsigned VMAX     = calc_max(VD, VF, VS, VB);
  localparam int unsigned HS_START = HD + HF;
  localparam int unsigned HS_END   = HD + HF + HS - 1;
  localparam int unsigned VS_START = VD + VF;
  localparam int unsigned VS_END   = VD + VF + VS - 1;
  localparam int unsigned DW       = $clog2(CLK_DIV);
  localparam int unsigned XSW      = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;
  localparam int unsigned YSW      = (Y_SCALE > 1) ? $clog2(Y_SCALE) : 1;
  localparam logic        H_ACT    = 1'(H_POL);
  localparam logic        V_ACT    = 1'(V_POL);
  localparam logic        H_IDLE   = ~H_ACT;
  localparam logic        V_IDLE   = ~V_ACT;

  if ((HMAX >> CW) != 0 || (VMAX >> CW) != 0) begin : g_cw_check
    $error("vga_timing_gen: HMAX/VMAX overflow CW bits");
  end
  if (CLK_DIV < 2 || PIPE > 8 || X_SCALE < 1 || Y_SCALE < 1) begin : g_param_check
    $error("vga_timing_gen: CLK_DIV/PIPE/X_SCALE/Y_SCALE out of range");
  end

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic          frame_start;
    logic          line_end;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } timing_t;

  localparam timing_t TIMING_RST = '{hsync: H_IDLE, vsync: V_IDLE, video_on: 1'b0,
                                     frame_start: 1'b0, line_end: 1'b0, x: '0, y: '0};

  logic [DW-1:0]  div;
  logic           tick_c;
  logic           h_wrap_c;
  logic           v_wrap_c;
  logic [XSW-1:0] xs;
  logic [YSW-1:0] ys;
  logic [CW-1:0]  x_cnt;
  logic [CW-1:0]  y_cnt;
  logic           loaded_q;
  timing_t        stage_c;
  timing_t        stage_q;
  timing_t        delayed;

  assign tick_c   = enable && (div == DW'(CLK_DIV - 1));
  assign p_tick   = tick_c;
  assign h_wrap_c = (h_count == CW'(HMAX));
  assign v_wrap_c = (v_count == CW'(VMAX));

  // Pixel-rate divider; frozen while enable is low.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n)    div <= '0;
    else if (enable) div <= tick_c ? '0 : div + 1'b1;
  end

  // Raw raster counters: v advances on the h wrap.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (tick_c) begin
      if (h_wrap_c) begin
        h_count <= '0;
        v_count <= v_wrap_c ? '0 : v_count + 1'b1;
      end else begin
        h_count <= h_count + 1'b1;
      end
    end
  end

  // Logical coordinate sub-counters; x tracks floor(h/X_SCALE), y floor(v/Y_SCALE).
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      xs    <= '0;
      x_cnt <= '0;
      ys    <= '0;
      y_cnt <= '0;
    end else if (tick_c) begin
      if (h_wrap_c) begin
        xs    <= '0;
        x_cnt <= '0;
        if (v_wrap_c) begin
          ys    <= '0;
          y_cnt <= '0;
        end else if (ys == YSW'(Y_SCALE - 1)) begin
          ys    <= '0;
          y_cnt <= y_cnt + 1'b1;
        end else begin
          ys <= ys + 1'b1;
        end
      end else if (xs == XSW'(X_SCALE - 1)) begin
        xs    <= '0;
        x_cnt <= x_cnt + 1'b1;
      end else begin
        xs <= xs + 1'b1;
      end
    end
  end

  // Decode the current raster position into the timing payload.
  always_comb begin
    stage_c             = TIMING_RST;
    stage_c.hsync       = (h_count >= CW'(HS_START) && h_count <= CW'(HS_END)) ? H_ACT : H_IDLE;
    stage_c.vsync       = (v_count >= CW'(VS_START) && v_count <= CW'(VS_END)) ? V_ACT : V_IDLE;
    stage_c.video_on    = (h_count < CW'(HD)) && (v_count < CW'(VD));
    stage_c.frame_start = (h_count == '0) && (v_count == '0);
    stage_c.line_end    = h_wrap_c;
    stage_c.x           = x_cnt;
    stage_c.y           = y_cnt;
  end

  // Timing stage (one pixel of latency) and the strobe qualifier.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      stage_q  <= TIMING_RST;
      loaded_q <= 1'b0;
    end else begin
      loaded_q <= tick_c;
      if (tick_c) stage_q <= stage_c;
    end
  end

  if (PIPE == 0) begin : g_no_pipe
    assign delayed = stage_q;
  end else begin : g_pipe
    vga_sync_delay #(
      .DEPTH  (PIPE),
      .WIDTH  ($bits(timing_t)),
      .RST_VAL(TIMING_RST)
    ) u_delay (
      .clk_100MHz(clk_100MHz),
      .reset_n   (reset_n),
      .en        (tick_c),
      .din       (stage_q),
      .dout      (delayed)
    );
  end

  assign hsync       = delayed.hsync;
  assign vsync       = delayed.vsync;
  assign video_on    = delayed.video_on;
  assign x           = delayed.x;
  assign y           = delayed.y;
  // Strobes last only the clk right after the final stage loads.
  assign frame_start = delayed.frame_start & loaded_q;
  assign line_end    = delayed.line_end & loaded_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance, an active-high/no-pipe sweep
// instance, and a tiny-mode instance for whole-frame and reset behaviour.
module tb_vga_timing_gen;

  logic clk_100MHz;
  logic reset_n;
  logic rst_c_n;
  logic enable;

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  logic        pt_a, hs_a, vs_a, vo_a, fs_a, le_a;
  logic [10:0] h_a, v_a, x_a, y_a;
  logic        pt_b, hs_b, vs_b, vo_b, fs_b, le_b;
  logic [10:0] h_b, v_b, x_b, y_b;
  logic        pt_c, hs_c, vs_c, vo_c, fs_c, le_c;
  logic [4:0]  h_c, v_c, x_c, y_c;

  vga_timing_gen dut_a (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .enable(enable), .p_tick(pt_a),
    .h_count(h_a), .v_count(v_a), .hsync(hs_a), .vsync(vs_a), .video_on(vo_a),
    .x(x_a), .y(y_a), .frame_start(fs_a), .line_end(le_a));

  vga_timing_gen #(.CLK_DIV(2), .H_POL(1), .V_POL(1), .PIPE(0), .X_SCALE(1), .Y_SCALE(1)) dut_b (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n), .enable(enable), .p_tick(pt_b),
    .h_count(h_b), .v_count(v_b), .hsync(hs_b), .vsync(vs_b), .video_on(vo_b),
    .x(x_b), .y(y_b), .frame_start(fs_b), .line_end(le_b));

  vga_timing_gen #(.CLK_DIV(2), .HD(8), .HF(2), .HS(3), .HB(3), .VD(6), .VF(2), .VS(2), .VB(2),
                   .X_SCALE(4), .Y_SCALE(2), .PIPE(2), .CW(5)) dut_c (
    .clk_100MHz(clk_100MHz), .reset_n(rst_c_n), .enable(enable), .p_tick(pt_c),
    .h_count(h_c), .v_count(v_c), .hsync(hs_c), .vsync(vs_c), .video_on(vo_c),
    .x(x_c), .y(y_c), .frame_start(fs_c), .line_end(le_c));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int n, ticks, hp, idx, src, vsrc, hsrc;
  int hs_low, vo_cnt, x_bad, le_clks, le_h, fs_clks, first_low, x639, x799;
  int ev, bx, bhs, bhs_hi, sync_bad, xy_bad, vs_low, y_vmax;
  logic [3:0] seq;

  initial begin
    reset_n = 1'b0;
    rst_c_n = 1'b0;
    enable  = 1'b1;
    repeat (3) @(negedge clk_100MHz);

    // Reset values
    chk("rst_h_a", 32'(h_a), 0);
    chk("rst_v_a", 32'(v_a), 0);
    chk("rst_ptick_a", 32'(pt_a), 0);
    chk("rst_hsync_a", 32'(hs_a), 1);
    chk("rst_vsync_a", 32'(vs_a), 1);
    chk("rst_video_a", 32'(vo_a), 0);
    chk("rst_xy_a", 32'({x_a, y_a}), 0);
    chk("rst_strobes_a", 32'({fs_a, le_a}), 0);
    chk("rst_hsync_b", 32'(hs_b), 0);
    chk("rst_vsync_b", 32'(vs_b), 0);

    // First p_tick is consumed by the 4th clk after release, then every 4 clk
    reset_n = 1'b1;
    rst_c_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_100MHz);
      seq[k] = pt_a;
    end
    chk("first_tick_seq", 32'(seq), 32'b0100);
    chk("h_after_first_tick", 32'(h_a), 1);
    n = 0;
    do begin @(negedge clk_100MHz); n++; end while (!pt_a && n < 20);
    n = 0;
    do begin @(negedge clk_100MHz); n++; end while (!pt_a && n < 20);
    chk("tick_period", n, 4);

    // One full line of delayed outputs (source line v=1)
    n = 0;
    while (!(v_a == 11'd1 && h_a == 11'd3) && n < 10000) begin @(negedge clk_100MHz); n++; end
    chk("reach_line1", 32'(v_a == 11'd1 && h_a == 11'd3), 1);
    ticks = 0; hs_low = 0; vo_cnt = 0; x_bad = 0; le_clks = 0; fs_clks = 0;
    first_low = -1; le_h = -1; x639 = -1; x799 = -1; n = 0;
    while (ticks < 800 && n < 4000) begin
      if (le_a) begin le_clks++; le_h = int'(h_a); end
      if (fs_a) fs_clks++;
      if (pt_a) begin
        hp = (int'(h_a) + 797) % 800;
        if (!hs_a) begin hs_low++; if (first_low < 0) first_low = int'(h_a); end
        if (vo_a) vo_cnt++;
        if (int'(x_a) != hp / 4) x_bad++;
        if (hp == 639) x639 = int'(x_a);
        if (hp == 799) x799 = int'(x_a);
        ticks++;
      end
      @(negedge clk_100MHz);
      n++;
    end
    chk("line_ticks", ticks, 800);
    chk("hsync_low_ticks", hs_low, 96);
    chk("hsync_fall_at_h", first_low, 659);
    chk("video_on_ticks", vo_cnt, 640);
    chk("x_map_errors", x_bad, 0);
    chk("x_at_639", x639, 159);
    chk("x_at_799", x799, 199);
    chk("line_end_clks", le_clks, 1);
    chk("line_end_at_h", le_h, 2);
    chk("no_frame_start", fs_clks, 0);
    chk("y_line1", 32'(y_a), 0);

    // Stall at h=300 for 50 clk
    n = 0;
    while (h_a != 11'd300 && n < 4000) begin @(negedge clk_100MHz); n++; end
    chk("reach_h300", 32'(h_a), 300);
    enable = 1'b0;
    ev = 0;
    repeat (50) begin
      @(negedge clk_100MHz);
      if (pt_a || fs_a || le_a) ev++;
    end
    chk("stall_h_hold", 32'(h_a), 300);
    chk("stall_events", ev, 0);
    chk("stall_x_hold", 32'(x_a), 74);
    chk("stall_hsync_hold", 32'(hs_a), 1);
    enable = 1'b1;
    ticks = 0; n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
      if (pt_a) ticks++;
    end while (!(h_a == 11'd300 && ticks > 1) && n < 5000);
    chk("line_ticks_after_stall", ticks, 800);

    // Sweep instance: active-high syncs, one pixel lag, x == h
    n = 0;
    while (!(h_b == 11'd0 && v_b != 11'd0) && n < 4000) begin @(negedge clk_100MHz); n++; end
    chk("b_reach_line_start", 32'(h_b), 0);
    ticks = 0; bx = 0; bhs = 0; bhs_hi = 0; n = 0;
    while (ticks < 800 && n < 4000) begin
      if (pt_b) begin
        hp = (int'(h_b) + 799) % 800;
        if (int'(x_b) != hp) bx++;
        if (hs_b !== (hp >= 656 && hp <= 751)) bhs++;
        if (hs_b) bhs_hi++;
        ticks++;
      end
      @(negedge clk_100MHz);
      n++;
    end
    chk("b_x_lag_errors", bx, 0);
    chk("b_hsync_pattern_errors", bhs, 0);
    chk("b_hsync_high_ticks", bhs_hi, 96);
    chk("b_vsync_idle", 32'(vs_b), 0);

    // Tiny-mode instance: one whole frame between frame_start pulses
    n = 0;
    while (!fs_c && n < 1000) begin @(negedge clk_100MHz); n++; end
    chk("c_fs_at_h", 32'(h_c), 3);
    chk("c_fs_at_v", 32'(v_c), 0);
    ticks = 0; sync_bad = 0; xy_bad = 0; vs_low = 0; vo_cnt = 0; le_clks = 0; y_vmax = -1; n = 0;
    do begin
      if (le_c) le_clks++;
      if (pt_c) begin
        idx  = int'(v_c) * 16 + int'(h_c);
        src  = (idx + 189) % 192;
        vsrc = src / 16;
        hsrc = src % 16;
        if (int'(x_c) != hsrc / 4 || int'(y_c) != vsrc / 2) xy_bad++;
        if (hs_c !== !(hsrc >= 10 && hsrc <= 12)) sync_bad++;
        if (vs_c !== !(vsrc >= 8 && vsrc <= 9)) sync_bad++;
        if (vo_c !== (hsrc < 8 && vsrc < 6)) sync_bad++;
        if (!vs_c) vs_low++;
        if (vo_c) vo_cnt++;
        if (src == 191) y_vmax = int'(y_c);
        ticks++;
      end
      @(negedge clk_100MHz);
      n++;
    end while (!fs_c && n < 1000);
    chk("c_frame_period_clks", n, 384);
    chk("c_frame_ticks", ticks, 192);
    chk("c_xy_errors", xy_bad, 0);
    chk("c_sync_video_errors", sync_bad, 0);
    chk("c_vsync_low_ticks", vs_low, 32);
    chk("c_video_on_ticks", vo_cnt, 48);
    chk("c_line_end_pulses", le_clks, 12);
    chk("c_y_at_vmax", y_vmax, 5);
    chk("c_y_after_wrap", 32'(y_c), 0);

    // Asynchronous reset in the middle of the vsync rows
    n = 0;
    while (!(v_c == 5'd8 && h_c == 5'd10) && n < 1000) begin @(negedge clk_100MHz); n++; end
    chk("c_vsync_active_before_rst", 32'(vs_c), 0);
    @(posedge clk_100MHz);
    #2 rst_c_n = 1'b0;
    #1;
    chk("c_rst_hv", 32'({h_c, v_c}), 0);
    chk("c_rst_syncs", 32'({hs_c, vs_c}), 3);
    chk("c_rst_xy", 32'({x_c, y_c}), 0);
    chk("c_rst_video_strobes", 32'({vo_c, fs_c, le_c, pt_c}), 0);
    @(negedge clk_100MHz);
    rst_c_n = 1'b1;
    n = 0;
    do begin @(negedge clk_100MHz); n++; end while (!fs_c && n < 50);
    chk("c_restart_fs_clks", n, 6);
    chk("c_restart_at_h", 32'(h_c), 3);
    chk("c_restart_at_v", 32'(v_c), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
